// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the RISC-V core.
package riscv_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// IF/ID handshake bundle between fetch (master) and decode (slave).
interface fetch_stage_if #(
   parameter int ADDRESS_WIDTH = 12
) ();

   logic                     id_valid;
   logic                     id_ready;
   logic [31:0]              id_instr;
   logic [ADDRESS_WIDTH-1:0] id_pc;
   logic [ADDRESS_WIDTH-1:0] id_pc_plus4;

   modport master (
      output id_valid, id_instr, id_pc, id_pc_plus4,
      input  id_ready
   );

   modport slave (
      input  id_valid, id_instr, id_pc, id_pc_plus4,
      output id_ready
   );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load captures a new word, flush only clears valid.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic                     flush,
   input  logic [31:0]              instr_d,
   input  logic [ADDRESS_WIDTH-1:0] pc_d,
   input  logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
   output logic                     valid,
   output logic [31:0]              instr,
   output logic [ADDRESS_WIDTH-1:0] pc,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= 1'b0;
         instr    <= NOP_INSTR;
         pc       <= '0;
         pc_plus4 <= '0;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= instr_d;
         pc       <= pc_d;
         pc_plus4 <= pc_plus4_d;
      end else if (flush) begin
         valid    <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, BOOT/RUN/HALT control and IF/ID register.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter int                       ADDRESS_WIDTH = 12,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [ADDRESS_WIDTH-1:0] rom_addr,
   input  logic [31:0]              rom_instr,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_target,
   input  logic                     halt_req,
   fetch_stage_if.master            id,
   output logic                     halted,
   output logic                     misaligned
);

   fetch_state_t             state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, pc_plus4;
   logic                     misaligned_q, misaligned_d;
   logic                     load, flush;

   assign pc_plus4   = pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
   assign rom_addr   = pc_q;
   assign halted     = (state_q == HALT);
   assign misaligned = misaligned_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         misaligned_q <= misaligned_d;
      end
   end

   // Redirect outranks stall and halt; a halting cycle may still drain an accepted word.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      misaligned_d = misaligned_q;
      load         = 1'b0;
      flush        = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (redirect_valid) begin
               flush = 1'b1;
               if (redirect_target[1:0] == 2'b00) begin
                  pc_d = redirect_target;
                  if (halt_req) state_d = HALT;
               end else begin
                  misaligned_d = 1'b1;
                  state_d      = HALT;
               end
            end else if (halt_req) begin
               state_d = HALT;
               flush   = id.id_valid && id.id_ready;
            end else if (!id.id_valid || id.id_ready) begin
               load = 1'b1;
               pc_d = pc_plus4;
            end else begin
               flush = id.id_valid && id.id_ready;
            end
         end
         HALT: flush = id.id_valid && id.id_ready;
         default: state_d = BOOT;
      endcase
   end

   if_id_reg #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .flush      (flush),
      .instr_d    (rom_instr),
      .pc_d       (pc_q),
      .pc_plus4_d (pc_plus4),
      .valid      (id.id_valid),
      .instr      (id.id_instr),
      .pc         (id.id_pc),
      .pc_plus4   (id.id_pc_plus4)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: program-order stream model plus directed edge cases.
module tb_fetch_stage;

   localparam int AW = 12;

   logic          clk;
   logic          rst;
   logic          id_ready;
   logic          redirect_valid;
   logic [AW-1:0] redirect_target;
   logic          halt_req;
   logic [AW-1:0] rom_addr, rom_addr_w;
   logic [31:0]   rom_instr, rom_instr_w;
   logic          halted, halted_w, misaligned, misaligned_w;
   logic [31:0]   rom [1024];

   int checks   = 0;
   int failures = 0;
   int n_accept = 0;

   // Expected program-order PCs still to be accepted by decode.
   logic [AW-1:0] exp_q [$];

   fetch_stage_if #(.ADDRESS_WIDTH(AW)) ifc ();
   fetch_stage_if #(.ADDRESS_WIDTH(AW)) ifw ();

   assign ifc.id_ready = id_ready;
   assign ifw.id_ready = 1'b1;
   assign rom_instr    = rom[rom_addr[AW-1:2]];
   assign rom_instr_w  = rom[rom_addr_w[AW-1:2]];

   fetch_stage #(.ADDRESS_WIDTH(AW), .RESET_PC(12'h000)) dut (
      .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_instr(rom_instr),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .halt_req(halt_req), .id(ifc), .halted(halted), .misaligned(misaligned)
   );

   fetch_stage #(.ADDRESS_WIDTH(AW), .RESET_PC(12'hFFC)) dut_w (
      .clk(clk), .rst(rst), .rom_addr(rom_addr_w), .rom_instr(rom_instr_w),
      .redirect_valid(1'b0), .redirect_target(12'h000),
      .halt_req(1'b0), .id(ifw), .halted(halted_w), .misaligned(misaligned_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic refill(input logic [AW-1:0] start);
      exp_q.delete();
      for (int i = 0; i < 512; i++) exp_q.push_back(start + AW'(i * 4));
   endtask

   // Monitor: a word is consumed when valid&&ready meet an edge with no redirect.
   always @(negedge clk) begin
      if (!rst && ifc.id_valid && id_ready && !redirect_valid) begin
         logic [AW-1:0] p;
         n_accept++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual_pc=0x%0h required=none", ifc.id_pc);
         end else begin
            p = exp_q.pop_front();
            check("sb_pc", ifc.id_pc, p);
            check("sb_instr", ifc.id_instr, rom[p[AW-1:2]]);
            check("sb_pc_plus4", ifc.id_pc_plus4, AW'(p + AW'(4)));
         end
      end
   end

   initial begin
      logic [AW-1:0] held_pc, saved_addr;
      rst             = 1'b1;
      id_ready        = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      halt_req        = 1'b0;
      for (int i = 0; i < 1024; i++) rom[i] = $urandom;
      rom[0] = 32'h1111_1111;
      rom[1] = 32'h2222_2222;
      rom[2] = 32'h3333_3333;

      tick();
      tick();
      check("rst_id_valid", ifc.id_valid, 0);
      check("rst_id_instr", ifc.id_instr, 32'h0000_0013);
      check("rst_id_pc", ifc.id_pc, 0);
      check("rst_id_pc_plus4", ifc.id_pc_plus4, 0);
      check("rst_halted", halted, 0);
      check("rst_misaligned", misaligned, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_rom_addr_w", rom_addr_w, 12'hFFC);

      rst = 1'b0;
      refill(12'h000);
      tick();
      check("boot_rom_addr", rom_addr, 0);
      check("boot_id_valid", ifc.id_valid, 0);
      tick();
      check("first_valid", ifc.id_valid, 1);
      check("first_instr", ifc.id_instr, 32'h1111_1111);
      check("first_pc", ifc.id_pc, 0);
      check("wrap_pc", ifw.id_pc, 12'hFFC);
      check("wrap_pc_plus4", ifw.id_pc_plus4, 12'h000);
      check("wrap_instr", ifw.id_instr, rom[1023]);
      tick();
      check("second_instr", ifc.id_instr, 32'h2222_2222);
      check("second_pc", ifc.id_pc, 4);
      check("wrap_next_pc", ifw.id_pc, 12'h000);
      check("wrap_next_plus4", ifw.id_pc_plus4, 12'h004);

      // Stall three cycles on pc 4.
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", ifc.id_pc, 4);
         check("stall_instr", ifc.id_instr, 32'h2222_2222);
         check("stall_rom_addr", rom_addr, 8);
      end
      id_ready = 1'b1;
      tick();
      check("post_stall_pc", ifc.id_pc, 8);
      check("post_stall_instr", ifc.id_instr, 32'h3333_3333);

      // Redirect while stalled on pc 8.
      id_ready = 1'b0;
      tick();
      check("pre_redirect_pc", ifc.id_pc, 8);
      redirect_valid  = 1'b1;
      redirect_target = 12'h100;
      refill(12'h100);
      tick();
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      check("redirect_flush", ifc.id_valid, 0);
      check("redirect_rom_addr", rom_addr, 12'h100);
      tick();
      check("redirect_valid", ifc.id_valid, 1);
      check("redirect_pc", ifc.id_pc, 12'h100);
      check("redirect_instr", ifc.id_instr, rom[12'h100 >> 2]);

      // Random ready/redirect traffic, checked by the scoreboard.
      for (int c = 0; c < 300; c++) begin
         id_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) begin
            redirect_valid  = 1'b1;
            redirect_target = AW'($urandom_range(0, 1023) * 4);
            refill(redirect_target);
         end else begin
            redirect_valid = 1'b0;
         end
         tick();
      end
      redirect_valid = 1'b0;

      // Halt while a word is held under stall.
      id_ready = 1'b0;
      tick();
      tick();
      check("halt_pre_valid", ifc.id_valid, 1);
      held_pc    = ifc.id_pc;
      saved_addr = rom_addr;
      halt_req   = 1'b1;
      tick();
      halt_req = 1'b0;
      check("halt_halted", halted, 1);
      check("halt_keep_valid", ifc.id_valid, 1);
      check("halt_keep_pc", ifc.id_pc, held_pc);
      tick();
      check("halt_still_valid", ifc.id_valid, 1);
      id_ready = 1'b1;
      tick();
      check("halt_drained", ifc.id_valid, 0);
      check("halt_rom_addr", rom_addr, saved_addr);
      tick();
      check("halt_stays", halted, 1);

      // Reset pulse back to BOOT.
      rst = 1'b1;
      tick();
      check("repulse_halted", halted, 0);
      check("repulse_rom_addr", rom_addr, 0);
      check("repulse_valid", ifc.id_valid, 0);
      rst = 1'b0;
      refill(12'h000);
      tick();
      tick();
      check("repulse_first_pc", ifc.id_pc, 0);
      check("repulse_first_instr", ifc.id_instr, 32'h1111_1111);
      tick();
      tick();

      // Misaligned redirect, then an ignored redirect in HALT.
      saved_addr      = rom_addr;
      redirect_valid  = 1'b1;
      redirect_target = 12'h102;
      tick();
      redirect_valid = 1'b0;
      check("mis_flag", misaligned, 1);
      check("mis_halted", halted, 1);
      check("mis_valid", ifc.id_valid, 0);
      check("mis_rom_addr", rom_addr, saved_addr);
      redirect_valid  = 1'b1;
      redirect_target = 12'h200;
      tick();
      redirect_valid = 1'b0;
      tick();
      check("mis_ignore_addr", rom_addr, saved_addr);
      check("mis_ignore_valid", ifc.id_valid, 0);
      check("mis_sticky", misaligned, 1);

      check("accept_count_ok", (n_accept >= 100), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
